// File: rtl/mib_slave_regfile.sv
// MIB bus register-file slave: decodes 24-bit byte addresses and serves 32-bit
// reads/writes to NUM_REGS control registers, with write strobes to local logic.
module mib_slave_regfile #(
  parameter int          ADDR_BITS = 24,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          NUM_REGS  = 16
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst,
  input  logic                       i_mib_start,
  input  logic                       i_mib_rd_wr_n,
  input  logic [15:0]                i_mib_d,
  output logic [15:0]                o_mib_d,
  output logic                       o_mib_d_oe,
  output logic                       o_mib_slave_ack,
  output logic [NUM_REGS*32-1:0]     o_regs,
  output logic                       o_wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] o_wr_idx
);

  localparam int IDXW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, WR_HI, WR_LO, WR_ACK, RD_TURN, RD_HI, RD_LO
  } state_t;

  state_t state, next_state;

  logic [7:0]           addr_hi;
  logic                 rd_q;
  logic                 hit_q;
  logic [IDXW-1:0]      idx_q;
  logic [15:0]          wdata_hi;
  logic [15:0]          rdata_lo;
  logic [31:0]          regs [NUM_REGS];
  logic [ADDR_BITS-1:0] addr;
  logic                 addr_hit;

  // Full address only exists during ADDR_LO, when the low half is on the bus.
  assign addr     = {addr_hi, i_mib_d};
  assign addr_hit = (addr[1:0] == 2'b00) &&
                    (addr[ADDR_BITS-1:IDXW+2] == BASE_ADDR[ADDR_BITS-1:IDXW+2]);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= next_state;
  end

  // Misses walk the same states as hits so the slave stays aligned with the bus.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_mib_start) next_state = ADDR_LO;
      ADDR_LO: next_state = rd_q ? RD_TURN : WR_HI;
      WR_HI:   next_state = WR_LO;
      WR_LO:   next_state = WR_ACK;
      WR_ACK:  next_state = IDLE;
      RD_TURN: next_state = RD_HI;
      RD_HI:   next_state = RD_LO;
      RD_LO:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      addr_hi  <= '0;
      rd_q     <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      wdata_hi <= '0;
      rdata_lo <= '0;
    end else begin
      if (state == IDLE && i_mib_start) begin
        addr_hi <= i_mib_d[7:0];
        rd_q    <= i_mib_rd_wr_n;
      end
      if (state == ADDR_LO) begin
        hit_q <= addr_hit;
        idx_q <= addr[IDXW+1:2];
      end
      if (state == WR_HI) wdata_hi <= i_mib_d;
      if (state == RD_TURN) rdata_lo <= regs[idx_q][15:0];
    end
  end

  // Outputs are registered one state ahead so they appear in the target state.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_mib_d         <= '0;
      o_mib_d_oe      <= 1'b0;
      o_mib_slave_ack <= 1'b0;
      o_wr_stb        <= 1'b0;
      o_wr_idx        <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      o_mib_d         <= '0;
      o_mib_d_oe      <= 1'b0;
      o_mib_slave_ack <= 1'b0;
      o_wr_stb        <= 1'b0;
      if (hit_q) begin
        case (state)
          WR_LO: begin
            regs[idx_q]     <= {wdata_hi, i_mib_d};
            o_mib_slave_ack <= 1'b1;
            o_wr_stb        <= 1'b1;
            o_wr_idx        <= idx_q;
          end
          RD_TURN: begin
            o_mib_d         <= regs[idx_q][31:16];
            o_mib_d_oe      <= 1'b1;
            o_mib_slave_ack <= 1'b1;
          end
          RD_HI: begin
            o_mib_d    <= rdata_lo;
            o_mib_d_oe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_mib_slave_regfile.sv
// Directed bench for mib_slave_regfile: bus writes/reads, misses, boundary,
// back-to-back traffic and asynchronous reset in the middle of a read.
module tb_mib_slave_regfile;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         mib_start;
  logic         mib_rd_wr_n;
  logic [15:0]  mib_d_in;
  logic [15:0]  mib_d_out;
  logic         mib_d_oe;
  logic         mib_ack;
  logic [511:0] regs_flat;
  logic         wr_stb;
  logic [3:0]   wr_idx;

  logic [31:0]  exp_regs [16];
  int           total = 0;
  int           bad   = 0;

  mib_slave_regfile #(
    .ADDR_BITS(24),
    .BASE_ADDR(24'h001000),
    .NUM_REGS (16)
  ) dut (
    .i_sys_clk      (sys_clk),
    .i_sys_rst      (sys_rst),
    .i_mib_start    (mib_start),
    .i_mib_rd_wr_n  (mib_rd_wr_n),
    .i_mib_d        (mib_d_in),
    .o_mib_d        (mib_d_out),
    .o_mib_d_oe     (mib_d_oe),
    .o_mib_slave_ack(mib_ack),
    .o_regs         (regs_flat),
    .o_wr_stb       (wr_stb),
    .o_wr_idx       (wr_idx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 16; k++)
      check_output($sformatf("%s_reg%0d", tag, k), regs_flat[32*k +: 32], exp_regs[k]);
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, "_oe"},  {31'd0, mib_d_oe}, 32'd0);
    check_output({tag, "_ack"}, {31'd0, mib_ack},  32'd0);
    check_output({tag, "_stb"}, {31'd0, wr_stb},   32'd0);
  endtask

  task automatic write_txn(input string tag, input logic [23:0] addr, input logic [31:0] data,
                           input logic hit, input logic [3:0] idx, input logic glitch);
    mib_start = 1'b1; mib_rd_wr_n = 1'b0; mib_d_in = {8'h00, addr[23:16]};
    check_quiet({tag, "_T0"});
    step;
    mib_start = 1'b0; mib_d_in = addr[15:0];
    check_quiet({tag, "_T1"});
    step;
    mib_d_in = data[31:16];
    if (glitch) begin
      mib_start = 1'b1; mib_rd_wr_n = 1'b1;
    end
    check_quiet({tag, "_T2"});
    step;
    mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_d_in = data[15:0];
    check_quiet({tag, "_T3"});
    step;
    mib_d_in = 16'h0000;
    if (hit) exp_regs[idx] = data;
    check_output({tag, "_T4_ack"}, {31'd0, mib_ack},  {31'd0, hit});
    check_output({tag, "_T4_stb"}, {31'd0, wr_stb},   {31'd0, hit});
    check_output({tag, "_T4_oe"},  {31'd0, mib_d_oe}, 32'd0);
    if (hit) check_output({tag, "_T4_idx"}, {28'd0, wr_idx}, {28'd0, idx});
    check_regs({tag, "_T4"});
    step;
    check_quiet({tag, "_T5"});
  endtask

  task automatic read_txn(input string tag, input logic [23:0] addr, input logic hit,
                          input logic [31:0] data);
    mib_start = 1'b1; mib_rd_wr_n = 1'b1; mib_d_in = {8'h00, addr[23:16]};
    check_quiet({tag, "_T0"});
    step;
    mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_d_in = addr[15:0];
    check_quiet({tag, "_T1"});
    step;
    mib_d_in = 16'h0000;
    check_quiet({tag, "_T2"});
    step;
    check_output({tag, "_T3_oe"},  {31'd0, mib_d_oe}, {31'd0, hit});
    check_output({tag, "_T3_ack"}, {31'd0, mib_ack},  {31'd0, hit});
    if (hit) check_output({tag, "_T3_d"}, {16'd0, mib_d_out}, {16'd0, data[31:16]});
    step;
    check_output({tag, "_T4_oe"},  {31'd0, mib_d_oe}, {31'd0, hit});
    check_output({tag, "_T4_ack"}, {31'd0, mib_ack},  32'd0);
    if (hit) check_output({tag, "_T4_d"}, {16'd0, mib_d_out}, {16'd0, data[15:0]});
    step;
    check_quiet({tag, "_T5"});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    sys_rst = 1'b1; mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_d_in = 16'h0000;
    #1;
    check_quiet("rst0");
    check_output("rst0_d",   {16'd0, mib_d_out}, 32'd0);
    check_output("rst0_idx", {28'd0, wr_idx},    32'd0);
    check_regs("rst0");
    step;
    step;
    sys_rst = 1'b0;
    step;

    $display("[TB] write/read reg 2");
    write_txn("wr2", 24'h001008, 32'hDEADBEEF, 1'b1, 4'd2, 1'b0);
    read_txn ("rd2", 24'h001008, 1'b1, 32'hDEADBEEF);

    $display("[TB] misses");
    write_txn("miss_range", 24'h002000, 32'h11111111, 1'b0, 4'd0, 1'b0);
    write_txn("miss_align", 24'h001002, 32'h22222222, 1'b0, 4'd0, 1'b0);
    read_txn ("rd2_after_miss", 24'h001008, 1'b1, 32'hDEADBEEF);

    $display("[TB] boundary");
    write_txn("wr15",      24'h00103C, 32'h12345678, 1'b1, 4'd15, 1'b0);
    write_txn("miss_over", 24'h001040, 32'h33333333, 1'b0, 4'd0,  1'b0);
    read_txn ("rd15",      24'h00103C, 1'b1, 32'h12345678);
    read_txn ("rd_miss",   24'h001040, 1'b0, 32'h0);

    $display("[TB] back-to-back with ignored start");
    write_txn("wr1_glitch", 24'h001004, 32'hA5A50F0F, 1'b1, 4'd1, 1'b1);
    read_txn ("rd1_b2b",    24'h001004, 1'b1, 32'hA5A50F0F);
    read_txn ("rd2_again",  24'h001008, 1'b1, 32'hDEADBEEF);

    $display("[TB] reset mid-read");
    mib_start = 1'b1; mib_rd_wr_n = 1'b1; mib_d_in = 16'h0000;
    step;
    mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_d_in = 16'h1008;
    step;
    mib_d_in = 16'h0000;
    step;
    check_output("rstmid_pre_oe",  {31'd0, mib_d_oe}, 32'd1);
    check_output("rstmid_pre_ack", {31'd0, mib_ack},  32'd1);
    sys_rst = 1'b1;
    #1;
    check_quiet("rstmid");
    check_output("rstmid_d", {16'd0, mib_d_out}, 32'd0);
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    step;
    sys_rst = 1'b0;
    step;
    check_regs("post_rst");
    read_txn("rd2_post_rst", 24'h001008, 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
